alu_reg_sequencer: RTL and testbench

//  Sequences one register-file + ALU datapath: accepts a command, reads two source registers, drives the ALU opcode,

---
 rtl/alu_reg_seq_pkg.sv | 27 ++
 rtl/alu_reg_sequencer_if.sv | 59 +++++
 rtl/alu_reg_sequencer.sv | 254 +++++++++++++++++++++++++
 tb/tb_alu_reg_sequencer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_reg_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_reg_seq_pkg
// Shared definitions for the register-file / ALU sequencer:
//   - default datapath widths (DEF_DATA_W, DEF_ADDR_W, DEF_OP_W)
//   - FSM state encoding (IDLE, READ, EXEC, WB_LO, WB_HI, DONE)
//   - command kind encoding (CMD_ALU, CMD_LDI)
// No ports (package).
// -----------------------------------------------------------------------------
package alu_reg_seq_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_OP_W   = 3;

    typedef logic [2:0] state_t;

    localparam state_t IDLE  = 3'd0;
    localparam state_t READ  = 3'd1;
    localparam state_t EXEC  = 3'd2;
    localparam state_t WB_LO = 3'd3;
    localparam state_t WB_HI = 3'd4;
    localparam state_t DONE  = 3'd5;

    localparam logic CMD_ALU = 1'b0;
    localparam logic CMD_LDI = 1'b1;

endpackage

// File: rtl/alu_reg_sequencer_if.sv
// -----------------------------------------------------------------------------
// alu_reg_sequencer_if
// Bundles the command handshake, reg_file control, ALU connection and
// result/flag reporting of the sequencer.
//   master : the sequencer itself (drives reg_file strobes, ALU opcode,
//            cmd_ready, done, res_out, flags)
//   slave  : the surrounding environment (command source, reg_file, ALU)
// Signals: cmd_valid/ready/kind/op/src_a/src_b/dst/imm, rf_wdata/sel_w/
//          sel_a/sel_b/en/rd/wr, alu_opcode/result/flagc/flagz,
//          done, res_out, flag_c, flag_z.
// -----------------------------------------------------------------------------
interface alu_reg_sequencer_if
    import alu_reg_seq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int OP_W   = DEF_OP_W
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_kind;
    logic [OP_W-1:0]     cmd_op;
    logic [ADDR_W-1:0]   cmd_src_a;
    logic [ADDR_W-1:0]   cmd_src_b;
    logic [ADDR_W-1:0]   cmd_dst;
    logic [DATA_W-1:0]   cmd_imm;

    logic [DATA_W-1:0]   rf_wdata;
    logic [ADDR_W-1:0]   rf_sel_w;
    logic [ADDR_W-1:0]   rf_sel_a;
    logic [ADDR_W-1:0]   rf_sel_b;
    logic                rf_en;
    logic                rf_rd;
    logic                rf_wr;

    logic [OP_W-1:0]     alu_opcode;
    logic [2*DATA_W-1:0] alu_result;
    logic                alu_flagc;
    logic                alu_flagz;

    logic                done;
    logic [2*DATA_W-1:0] res_out;
    logic                flag_c;
    logic                flag_z;

    modport master (
        input  cmd_valid, cmd_kind, cmd_op, cmd_src_a, cmd_src_b, cmd_dst, cmd_imm,
        input  alu_result, alu_flagc, alu_flagz,
        output cmd_ready, rf_wdata, rf_sel_w, rf_sel_a, rf_sel_b, rf_en, rf_rd, rf_wr,
        output alu_opcode, done, res_out, flag_c, flag_z
    );

    modport slave (
        output cmd_valid, cmd_kind, cmd_op, cmd_src_a, cmd_src_b, cmd_dst, cmd_imm,
        output alu_result, alu_flagc, alu_flagz,
        input  cmd_ready, rf_wdata, rf_sel_w, rf_sel_a, rf_sel_b, rf_en, rf_rd, rf_wr,
        input  alu_opcode, done, res_out, flag_c, flag_z
    );
endinterface

// File: rtl/alu_reg_sequencer.sv
// -----------------------------------------------------------------------------
// alu_reg_sequencer
// Runs one command at a time through a reg_file + ALU pair:
//   ALU op   : IDLE -> READ -> EXEC -> WB_LO [-> WB_HI] -> DONE -> IDLE
//   load-imm : IDLE -> WB_LO -> DONE -> IDLE
// Ports:
//   clk  : single clock, posedge
//   rst  : synchronous active-low reset
//   bus  : alu_reg_sequencer_if.master (command, reg_file, ALU, results)
// Build option: define ALU_REG_WB_HI_EN to add the WB_HI state, which writes
// the upper half of the ALU result to register (dst+1), wrapping at the top.
// All outputs are registered: the output decode looks at the next state and
// the next command/result values, so each registered output lines up with
// the state it belongs to.
// -----------------------------------------------------------------------------
module alu_reg_sequencer
    import alu_reg_seq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int OP_W   = DEF_OP_W
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_reg_sequencer_if.master  bus
);

    state_t              state_r;
    state_t              state_s;
    logic                accept_s;

    logic                lat_kind_r;
    logic [OP_W-1:0]     lat_op_r;
    logic [ADDR_W-1:0]   lat_src_a_r;
    logic [ADDR_W-1:0]   lat_src_b_r;
    logic [ADDR_W-1:0]   lat_dst_r;
    logic [DATA_W-1:0]   lat_imm_r;
    logic [2*DATA_W-1:0] res_r;
    logic                flag_c_r;
    logic                flag_z_r;

    // Command / result values as they will be after the coming edge.
    logic                fld_kind_s;
    logic [OP_W-1:0]     fld_op_s;
    logic [ADDR_W-1:0]   fld_src_a_s;
    logic [ADDR_W-1:0]   fld_src_b_s;
    logic [ADDR_W-1:0]   fld_dst_s;
    logic [DATA_W-1:0]   fld_imm_s;
    logic [2*DATA_W-1:0] res_s;

    logic                cmd_ready_s, rf_en_s, rf_rd_s, rf_wr_s, done_s;
    logic [ADDR_W-1:0]   rf_sel_a_s, rf_sel_b_s, rf_sel_w_s;
    logic [DATA_W-1:0]   rf_wdata_s;
    logic [OP_W-1:0]     alu_opcode_s;

    logic                cmd_ready_r, rf_en_r, rf_rd_r, rf_wr_r, done_r;
    logic [ADDR_W-1:0]   rf_sel_a_r, rf_sel_b_r, rf_sel_w_r;
    logic [DATA_W-1:0]   rf_wdata_r;
    logic [OP_W-1:0]     alu_opcode_r;

    // Commands are only taken in IDLE; inputs are ignored everywhere else.
    assign accept_s = (state_r == IDLE) && bus.cmd_valid;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = IDLE;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (bus.cmd_kind == CMD_LDI) begin
                        state_s = WB_LO;
                    end else begin
                        state_s = READ;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            READ:  state_s = EXEC;
            EXEC:  state_s = WB_LO;
            WB_LO: begin
`ifdef ALU_REG_WB_HI_EN
                if (lat_kind_r == CMD_ALU) begin
                    state_s = WB_HI;
                end else begin
                    state_s = DONE;
                end
`else
                state_s = DONE;
`endif
            end
`ifdef ALU_REG_WB_HI_EN
            WB_HI: state_s = DONE;
`endif
            DONE:  state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Command latch plus result/flag capture at the end of EXEC; reset
    // discards any half-run command.
    always_ff @(posedge clk) begin
        if (!rst) begin
            lat_kind_r  <= 1'b0;
            lat_op_r    <= '0;
            lat_src_a_r <= '0;
            lat_src_b_r <= '0;
            lat_dst_r   <= '0;
            lat_imm_r   <= '0;
            res_r       <= '0;
            flag_c_r    <= 1'b0;
            flag_z_r    <= 1'b0;
        end else begin
            if (accept_s) begin
                lat_kind_r  <= bus.cmd_kind;
                lat_op_r    <= bus.cmd_op;
                lat_src_a_r <= bus.cmd_src_a;
                lat_src_b_r <= bus.cmd_src_b;
                lat_dst_r   <= bus.cmd_dst;
                lat_imm_r   <= bus.cmd_imm;
            end
            if (state_r == EXEC) begin
                res_r    <= bus.alu_result;
                flag_c_r <= bus.alu_flagc;
                flag_z_r <= bus.alu_flagz;
            end
        end
    end

    // Look-ahead view of latched command and result for the output decode.
    always_comb begin
        if (accept_s) begin
            fld_kind_s  = bus.cmd_kind;
            fld_op_s    = bus.cmd_op;
            fld_src_a_s = bus.cmd_src_a;
            fld_src_b_s = bus.cmd_src_b;
            fld_dst_s   = bus.cmd_dst;
            fld_imm_s   = bus.cmd_imm;
        end else begin
            fld_kind_s  = lat_kind_r;
            fld_op_s    = lat_op_r;
            fld_src_a_s = lat_src_a_r;
            fld_src_b_s = lat_src_b_r;
            fld_dst_s   = lat_dst_r;
            fld_imm_s   = lat_imm_r;
        end
        if (state_r == EXEC) begin
            res_s = bus.alu_result;
        end else begin
            res_s = res_r;
        end
    end

    // FSM output decode from the next state.
    always_comb begin
        cmd_ready_s  = 1'b0;
        rf_en_s      = 1'b0;
        rf_rd_s      = 1'b0;
        rf_wr_s      = 1'b0;
        done_s       = 1'b0;
        rf_sel_a_s   = '0;
        rf_sel_b_s   = '0;
        rf_sel_w_s   = '0;
        rf_wdata_s   = '0;
        alu_opcode_s = '0;
        case (state_s)
            IDLE: cmd_ready_s = 1'b1;
            READ: begin
                rf_en_s    = 1'b1;
                rf_rd_s    = 1'b1;
                rf_sel_a_s = fld_src_a_s;
                rf_sel_b_s = fld_src_b_s;
            end
            EXEC: begin
                rf_en_s      = 1'b1;
                rf_rd_s      = 1'b1;
                rf_sel_a_s   = fld_src_a_s;
                rf_sel_b_s   = fld_src_b_s;
                alu_opcode_s = fld_op_s;
            end
            WB_LO: begin
                rf_en_s    = 1'b1;
                rf_wr_s    = 1'b1;
                rf_sel_w_s = fld_dst_s;
                if (fld_kind_s == CMD_LDI) begin
                    rf_wdata_s = fld_imm_s;
                end else begin
                    rf_wdata_s = res_s[DATA_W-1:0];
                end
            end
`ifdef ALU_REG_WB_HI_EN
            WB_HI: begin
                rf_en_s    = 1'b1;
                rf_wr_s    = 1'b1;
                rf_sel_w_s = fld_dst_s + ADDR_W'(1);
                rf_wdata_s = res_s[2*DATA_W-1:DATA_W];
            end
`endif
            DONE: done_s = 1'b1;
            default: cmd_ready_s = 1'b0;
        endcase
    end

    // Output registers; reset leaves only cmd_ready high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cmd_ready_r  <= 1'b1;
            rf_en_r      <= 1'b0;
            rf_rd_r      <= 1'b0;
            rf_wr_r      <= 1'b0;
            done_r       <= 1'b0;
            rf_sel_a_r   <= '0;
            rf_sel_b_r   <= '0;
            rf_sel_w_r   <= '0;
            rf_wdata_r   <= '0;
            alu_opcode_r <= '0;
        end else begin
            cmd_ready_r  <= cmd_ready_s;
            rf_en_r      <= rf_en_s;
            rf_rd_r      <= rf_rd_s;
            rf_wr_r      <= rf_wr_s;
            done_r       <= done_s;
            rf_sel_a_r   <= rf_sel_a_s;
            rf_sel_b_r   <= rf_sel_b_s;
            rf_sel_w_r   <= rf_sel_w_s;
            rf_wdata_r   <= rf_wdata_s;
            alu_opcode_r <= alu_opcode_s;
        end
    end

    assign bus.cmd_ready  = cmd_ready_r;
    assign bus.rf_en      = rf_en_r;
    assign bus.rf_rd      = rf_rd_r;
    assign bus.rf_wr      = rf_wr_r;
    assign bus.rf_sel_a   = rf_sel_a_r;
    assign bus.rf_sel_b   = rf_sel_b_r;
    assign bus.rf_sel_w   = rf_sel_w_r;
    assign bus.rf_wdata   = rf_wdata_r;
    assign bus.alu_opcode = alu_opcode_r;
    assign bus.done       = done_r;
    assign bus.res_out    = res_r;
    assign bus.flag_c     = flag_c_r;
    assign bus.flag_z     = flag_z_r;

endmodule

// File: tb/tb_alu_reg_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_reg_sequencer
// Bench for alu_reg_sequencer with a behavioural reg_file (1-cycle read) and
// a combinational ALU. A reference model keeps the architectural register
// contents, last ALU result and flags, and the expected write list and
// latency of each command. Honours ALU_REG_WB_HI_EN.
// -----------------------------------------------------------------------------
module tb_alu_reg_sequencer;
    import alu_reg_seq_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    alu_reg_sequencer_if bus ();

    alu_reg_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        kind;
        logic [2:0]  op;
        logic [3:0]  a;
        logic [3:0]  b;
        logic [3:0]  dst;
        logic [31:0] imm;
    } tcmd_t;

    int total = 0;
    int bad   = 0;

    // Environment: reg_file and ALU.
    logic [31:0] regs [16] = '{default: 32'h0};
    logic [31:0] rd_a = 32'h0;
    logic [31:0] rd_b = 32'h0;

    always @(posedge clk) begin
        if (bus.rf_en && bus.rf_wr) regs[bus.rf_sel_w] <= bus.rf_wdata;
        if (bus.rf_en && bus.rf_rd) begin
            rd_a <= regs[bus.rf_sel_a];
            rd_b <= regs[bus.rf_sel_b];
        end
    end

    function automatic logic [63:0] alu_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0: alu_fn = {32'h0, a} + {32'h0, b};
            3'd1: alu_fn = {32'h0, a} - {32'h0, b};
            3'd2: alu_fn = {32'h0, a & b};
            3'd3: alu_fn = {32'h0, a | b};
            3'd4: alu_fn = {32'h0, a ^ b};
            3'd5: alu_fn = {32'h0, a} * {32'h0, b};
            3'd6: alu_fn = {32'h0, a} << b[4:0];
            default: alu_fn = {32'h0, ~a};
        endcase
    endfunction

    assign bus.alu_result = alu_fn(bus.alu_opcode, rd_a, rd_b);
    assign bus.alu_flagc  = bus.alu_result[32];
    assign bus.alu_flagz  = (bus.alu_result == 64'd0);

    // Bus monitor sampled mid-cycle.
    logic [3:0]  wr_sel_q [$];
    logic [31:0] wr_dat_q [$];
    int overlap_n = 0;
    int en_bad_n  = 0;
    int done_n    = 0;

    always @(negedge clk) begin
        if (bus.rf_wr === 1'b1) begin
            wr_sel_q.push_back(bus.rf_sel_w);
            wr_dat_q.push_back(bus.rf_wdata);
        end
        if (bus.rf_rd === 1'b1 && bus.rf_wr === 1'b1) overlap_n++;
        if ((bus.rf_rd === 1'b1 || bus.rf_wr === 1'b1) && bus.rf_en !== 1'b1) en_bad_n++;
        if (bus.done === 1'b1) done_n++;
    end

    // Reference model state.
    logic [31:0] m_regs [16] = '{default: 32'h0};
    logic [63:0] m_res = 64'h0;
    logic        m_c   = 1'b0;
    logic        m_z   = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic tcmd_t mk(input logic kind, input logic [2:0] op, input logic [3:0] a,
                                 input logic [3:0] b, input logic [3:0] dst, input logic [31:0] imm);
        tcmd_t c;
        c.kind = kind; c.op = op; c.a = a; c.b = b; c.dst = dst; c.imm = imm;
        return c;
    endfunction

    function automatic int reg_diff();
        int n = 0;
        for (int i = 0; i < 16; i++) if (regs[i] !== m_regs[i]) n++;
        return n;
    endfunction

    task automatic drive(input tcmd_t c, input logic valid);
        bus.cmd_valid = valid;
        bus.cmd_kind  = c.kind;
        bus.cmd_op    = c.op;
        bus.cmd_src_a = c.a;
        bus.cmd_src_b = c.b;
        bus.cmd_dst   = c.dst;
        bus.cmd_imm   = c.imm;
    endtask

    // Issue one command, optionally keep cmd_valid high with other fields
    // afterwards, and check latency, writes, results and register contents.
    task automatic run_cmd(input tcmd_t c, input bit hold, input tcmd_t nxt);
        logic [3:0]  esel [$];
        logic [31:0] edat [$];
        logic [63:0] r;
        int lat, w, exp_lat, d0;
        w = 0;
        while (bus.cmd_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("ready_before_cmd", 64'(bus.cmd_ready), 64'd1);
        if (c.kind == CMD_LDI) begin
            esel.push_back(c.dst);
            edat.push_back(c.imm);
            m_regs[c.dst] = c.imm;
            exp_lat = 2;
        end else begin
            r = alu_fn(c.op, m_regs[c.a], m_regs[c.b]);
            m_res = r;
            m_c = r[32];
            m_z = (r == 64'd0);
            esel.push_back(c.dst);
            edat.push_back(r[31:0]);
            m_regs[c.dst] = r[31:0];
`ifdef ALU_REG_WB_HI_EN
            esel.push_back(c.dst + 4'd1);
            edat.push_back(r[63:32]);
            m_regs[c.dst + 4'd1] = r[63:32];
            exp_lat = 5;
`else
            exp_lat = 4;
`endif
        end
        wr_sel_q.delete();
        wr_dat_q.delete();
        d0 = done_n;
        drive(c, 1'b1);
        @(negedge clk);
        lat = 1;
        if (hold) drive(nxt, 1'b1);
        else bus.cmd_valid = 1'b0;
        while (bus.done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("done_latency", 64'(lat), 64'(exp_lat));
        chk("ready_low_in_done", 64'(bus.cmd_ready), 64'd0);
        @(negedge clk);
        chk("ready_after_done", 64'(bus.cmd_ready), 64'd1);
        chk("done_pulses", 64'(done_n - d0), 64'd1);
        chk("wr_count", 64'(wr_sel_q.size()), 64'(esel.size()));
        for (int i = 0; i < esel.size() && i < wr_sel_q.size(); i++) begin
            chk("wr_sel", 64'(wr_sel_q[i]), 64'(esel[i]));
            chk("wr_data", 64'(wr_dat_q[i]), 64'(edat[i]));
        end
        chk("res_out", bus.res_out, m_res);
        chk("flag_c", 64'(bus.flag_c), 64'(m_c));
        chk("flag_z", 64'(bus.flag_z), 64'(m_z));
        chk("reg_diff", 64'(reg_diff()), 64'd0);
    endtask

    tcmd_t idle_c;
    tcmd_t ca;
    tcmd_t cb;
    int d0;

    initial begin
        idle_c = mk(1'b0, 3'd0, 4'd0, 4'd0, 4'd0, 32'h0);
        drive(idle_c, 1'b0);

        // Reset state.
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        chk("rst_rf_wr", 64'(bus.rf_wr), 64'd0);
        chk("rst_rf_rd", 64'(bus.rf_rd), 64'd0);
        chk("rst_rf_en", 64'(bus.rf_en), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_res_out", bus.res_out, 64'd0);
        chk("rst_flag_c", 64'(bus.flag_c), 64'd0);
        chk("rst_flag_z", 64'(bus.flag_z), 64'd0);
        chk("rst_sel_w", 64'(bus.rf_sel_w), 64'd0);
        chk("rst_wdata", 64'(bus.rf_wdata), 64'd0);
        chk("rst_opcode", 64'(bus.alu_opcode), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Load immediate.
        run_cmd(mk(CMD_LDI, 3'd0, 4'd0, 4'd0, 4'd3, 32'hDEADBEEF), 1'b0, idle_c);
        chk("ldi_r3", 64'(regs[3]), 64'h0000_0000_DEAD_BEEF);

        // Simple add.
        run_cmd(mk(CMD_LDI, 3'd0, 4'd0, 4'd0, 4'd1, 32'd5), 1'b0, idle_c);
        run_cmd(mk(CMD_LDI, 3'd0, 4'd0, 4'd0, 4'd2, 32'd7), 1'b0, idle_c);
        run_cmd(mk(CMD_ALU, 3'd0, 4'd1, 4'd2, 4'd4, 32'h0), 1'b0, idle_c);
        chk("add_r4", 64'(regs[4]), 64'd12);
        chk("add_res", bus.res_out, 64'd12);
        chk("add_flag_z", 64'(bus.flag_z), 64'd0);

        // Carry-out add into the top register (upper half wraps to R0).
        run_cmd(mk(CMD_LDI, 3'd0, 4'd0, 4'd0, 4'd1, 32'hFFFFFFFF), 1'b0, idle_c);
        run_cmd(mk(CMD_LDI, 3'd0, 4'd0, 4'd0, 4'd2, 32'hFFFFFFFF), 1'b0, idle_c);
        run_cmd(mk(CMD_ALU, 3'd0, 4'd1, 4'd2, 4'd15, 32'h0), 1'b0, idle_c);
        chk("carry_r15", 64'(regs[15]), 64'h0000_0000_FFFF_FFFE);
        chk("carry_res", bus.res_out, 64'h0000_0001_FFFF_FFFE);
        chk("carry_flag_c", 64'(bus.flag_c), 64'd1);
`ifdef ALU_REG_WB_HI_EN
        chk("carry_r0_wrap", 64'(regs[0]), 64'd1);
`else
        chk("carry_r0_untouched", 64'(regs[0]), 64'd0);
`endif

        // cmd_valid held through a busy command with changing fields.
        ca = mk(CMD_ALU, 3'd2, 4'd3, 4'd1, 4'd5, 32'h0);
        cb = mk(CMD_ALU, 3'd4, 4'd1, 4'd3, 4'd7, 32'h55AA55AA);
        run_cmd(ca, 1'b1, cb);
        run_cmd(cb, 1'b0, idle_c);

        // Reset while in EXEC aborts the command.
        run_cmd(mk(CMD_LDI, 3'd0, 4'd0, 4'd0, 4'd6, 32'h12345678), 1'b0, idle_c);
        wr_sel_q.delete();
        wr_dat_q.delete();
        d0 = done_n;
        drive(mk(CMD_ALU, 3'd0, 4'd1, 4'd2, 4'd6, 32'h0), 1'b1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("abort_in_exec_rd", 64'(bus.rf_rd), 64'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ready", 64'(bus.cmd_ready), 64'd1);
        chk("abort_rf_en", 64'(bus.rf_en), 64'd0);
        chk("abort_rf_wr", 64'(bus.rf_wr), 64'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        m_res = 64'h0;
        m_c = 1'b0;
        m_z = 1'b0;
        chk("abort_no_write", 64'(wr_sel_q.size()), 64'd0);
        chk("abort_no_done", 64'(done_n - d0), 64'd0);
        chk("abort_r6", 64'(regs[6]), 64'h0000_0000_1234_5678);
        chk("abort_res_out", bus.res_out, m_res);
        chk("abort_reg_diff", 64'(reg_diff()), 64'd0);

        // Random commands.
        for (int k = 0; k < 24; k++) begin
            tcmd_t rc;
            rc.kind = ($urandom_range(0, 3) == 0) ? CMD_LDI : CMD_ALU;
            rc.op   = 3'($urandom_range(0, 7));
            rc.a    = 4'($urandom_range(0, 15));
            rc.b    = 4'($urandom_range(0, 15));
            rc.dst  = 4'($urandom_range(0, 15));
            rc.imm  = $urandom;
            run_cmd(rc, 1'b0, idle_c);
        end

        chk("rd_wr_overlap", 64'(overlap_n), 64'd0);
        chk("strobe_without_en", 64'(en_bad_n), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
